// File: rtl/irq_pkg.sv
// Shared constants and FSM state type for the interrupt request latch.
package irq_pkg;
    localparam int IRQ_N     = 8;
    localparam int IRQ_IDX_W = 3;

    typedef enum logic [1:0] {
        IRQ_IDLE,
        IRQ_PRESENT,
        IRQ_GAP
    } irq_state_t;
endpackage

// File: rtl/irq_edge_sync.sv
// Rising-edge detector for the request lines, with an optional 2-flop
// synchroniser in front (enabled by defining IRQ_SYNC_EN).
module irq_edge_sync
    import irq_pkg::*;
#(
    parameter int N = IRQ_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] irq_in,
    output logic [N-1:0] rise
);
    logic [N-1:0] s;
    logic [N-1:0] s_q;

`ifdef IRQ_SYNC_EN
    logic [N-1:0] sync1;
    logic [N-1:0] sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq_in;
            sync2 <= sync1;
        end
    end

    assign s = sync2;
`else
    assign s = irq_in;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s_q <= '0;
        else        s_q <= s;
    end

    assign rise = s & ~s_q;
endmodule

// File: rtl/irq_request_latch.sv
// Sticky request latch feeding the 8-to-3 priority encoder; holds a frozen
// snapshot until acked. Define IRQ_SYNC_EN to synchronise irq_in first.
module irq_request_latch
    import irq_pkg::*;
#(
    parameter int N     = IRQ_N,
    parameter int IDX_W = IRQ_IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     irq_in,
    input  logic [N-1:0]     mask,
    input  logic             ack,
    input  logic [IDX_W-1:0] ack_idx,
    output logic [N-1:0]     d_out,
    output logic             en_out,
    output logic             ack_err,
    output logic [N-1:0]     overrun
);
    logic [N-1:0] rise;
    logic [N-1:0] pending;
    logic [N-1:0] clr;
    logic [N-1:0] visible;
    logic         ack_ok;

    irq_state_t   state;
    irq_state_t   state_nxt;
    logic [N-1:0] d_nxt;
    logic         en_nxt;
    logic         err_nxt;

    irq_edge_sync #(.N(N)) u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .irq_in (irq_in),
        .rise   (rise)
    );

    assign visible = pending & ~mask;
    assign ack_ok  = (state == IRQ_PRESENT) && ack && d_out[ack_idx];

    always_comb begin
        clr = '0;
        if (ack_ok) clr[ack_idx] = 1'b1;
    end

    // A fresh edge beats a same-cycle clear, and never counts as an overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            overrun <= '0;
        end else begin
            pending <= (pending & ~clr) | rise;
            overrun <= (overrun & ~clr) | (rise & pending & ~clr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IRQ_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IRQ_IDLE:    if (|visible) state_nxt = IRQ_PRESENT;
            IRQ_PRESENT: if (ack_ok)   state_nxt = IRQ_GAP;
            IRQ_GAP:                   state_nxt = IRQ_IDLE;
            default:                   state_nxt = IRQ_IDLE;
        endcase
    end

    always_comb begin
        d_nxt   = '0;
        en_nxt  = 1'b0;
        err_nxt = ack && !ack_ok;
        case (state)
            IRQ_IDLE: begin
                if (|visible) begin
                    d_nxt  = visible;
                    en_nxt = 1'b1;
                end
            end
            IRQ_PRESENT: begin
                if (!ack_ok) begin
                    d_nxt  = d_out;
                    en_nxt = 1'b1;
                end
            end
            default: begin
                d_nxt  = '0;
                en_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_out   <= '0;
            en_out  <= 1'b0;
            ack_err <= 1'b0;
        end else begin
            d_out   <= d_nxt;
            en_out  <= en_nxt;
            ack_err <= err_nxt;
        end
    end
endmodule

// File: tb/tb_irq_request_latch.sv
// Scoreboard bench for irq_request_latch: directed scenarios plus random
// traffic, each cycle checked against a behavioural model of the latch.
module tb_irq_request_latch;
`ifdef IRQ_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irq_in;
    logic [7:0] mask;
    logic       ack;
    logic [2:0] ack_idx;
    logic [7:0] d_out;
    logic       en_out;
    logic       ack_err;
    logic [7:0] overrun;

    irq_request_latch dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .irq_in  (irq_in),
        .mask    (mask),
        .ack     (ack),
        .ack_idx (ack_idx),
        .d_out   (d_out),
        .en_out  (en_out),
        .ack_err (ack_err),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       en;
        logic [7:0] d;
        logic       err;
        logic [7:0] ov;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model: sticky request set, the snapshot being serviced (0 = none),
    // and whether the one-cycle gap after a service is in progress.
    logic [7:0] m_pend, m_over, m_snap, m_prev, m_d1, m_d2;
    logic       m_gap;
    logic [7:0] cur_irq, cur_mask;

    function automatic void model_reset();
        m_pend = '0; m_over = '0; m_snap = '0; m_prev = '0;
        m_d1 = '0; m_d2 = '0; m_gap = 1'b0;
    endfunction

    function automatic void model_edge(input logic [7:0] irq, input logic [7:0] msk,
                                       input logic a, input logic [2:0] ai);
        logic [7:0] s, rise, clr, old_pend;
        logic       valid, err;
        obs_t       e;
        s = (SYNC_LAT > 0) ? m_d2 : irq;
        m_d2 = m_d1;
        m_d1 = irq;
        rise = s & ~m_prev;
        m_prev = s;
        valid = a && m_snap[ai];
        err = a && !valid;
        clr = valid ? (8'd1 << ai) : 8'd0;
        old_pend = m_pend;
        m_over = (m_over & ~clr) | (rise & m_pend & ~clr);
        m_pend = (m_pend & ~clr) | rise;
        if (m_gap) m_gap = 1'b0;
        else if (m_snap != 0) begin
            if (valid) begin
                m_snap = '0;
                m_gap = 1'b1;
            end
        end else if ((old_pend & ~msk) != 0) m_snap = old_pend & ~msk;
        e.en = (m_snap != 0);
        e.d = m_snap;
        e.err = err;
        e.ov = m_over;
        exp_q.push_back(e);
    endfunction

    initial begin
        obs_t e, g;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = {en_out, d_out, ack_err, overrun};
                n_checks++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard t=%0t: got en=%0b d=%h err=%0b ov=%h, expected en=%0b d=%h err=%0b ov=%h",
                             $time, g.en, g.d, g.err, g.ov, e.en, e.d, e.err, e.ov);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic step(input logic [7:0] irq, input logic [7:0] msk,
                        input logic a = 1'b0, input logic [2:0] ai = 3'd0);
        @(negedge clk);
        irq_in = irq; mask = msk; ack = a; ack_idx = ai;
        cur_irq = irq; cur_mask = msk;
        model_edge(irq, msk, a, ai);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) step(cur_irq, cur_mask);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ri, rm;
        logic       ra;
        logic [2:0] rx;
        rst_n = 1'b0; irq_in = '0; mask = '0; ack = 1'b0; ack_idx = '0;
        cur_irq = '0; cur_mask = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset en_out", {7'd0, en_out}, 8'h00);
        chk("reset d_out", d_out, 8'h00);
        chk("reset overrun", overrun, 8'h00);
        chk("reset ack_err", {7'd0, ack_err}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // single line, ack 5
        step(8'h20, 8'h00); hold(SYNC_LAT); step(8'h20, 8'h00); settle();
        chk("t1 en_out", {7'd0, en_out}, 8'h01);
        chk("t1 d_out", d_out, 8'h20);
        step(8'h20, 8'h00, 1'b1, 3'd5); settle();
        chk("t1 gap en_out", {7'd0, en_out}, 8'h00);
        step(8'h20, 8'h00); step(8'h20, 8'h00); settle();
        chk("t1 idle en_out", {7'd0, en_out}, 8'h00);

        // two simultaneous lines, serviced one after the other
        step(8'h81, 8'h00); hold(SYNC_LAT); step(8'h81, 8'h00); settle();
        chk("t2 d_out", d_out, 8'h81);
        step(8'h81, 8'h00, 1'b1, 3'd7); step(8'h81, 8'h00); step(8'h81, 8'h00); settle();
        chk("t2 second d_out", d_out, 8'h01);
        step(8'h81, 8'h00, 1'b1, 3'd0); step(8'h81, 8'h00); step(8'h81, 8'h00);

        // mask hides line 7; bad ack; unmask reveals it
        step(8'h00, 8'h80); hold(SYNC_LAT);
        step(8'h84, 8'h80); hold(SYNC_LAT); step(8'h84, 8'h80); settle();
        chk("t3 masked d_out", d_out, 8'h04);
        step(8'h84, 8'h80, 1'b1, 3'd3); settle();
        chk("t3 ack_err", {7'd0, ack_err}, 8'h01);
        chk("t3 d_out held", d_out, 8'h04);
        chk("t3 en_out held", {7'd0, en_out}, 8'h01);
        step(8'h84, 8'h80); settle();
        chk("t3 ack_err one cycle", {7'd0, ack_err}, 8'h00);
        step(8'h84, 8'h80, 1'b1, 3'd2); step(8'h84, 8'h00); step(8'h84, 8'h00); settle();
        chk("t3 unmasked d_out", d_out, 8'h80);
        step(8'h84, 8'h00, 1'b1, 3'd7); step(8'h84, 8'h00); step(8'h84, 8'h00);

        // overrun on line 4
        step(8'h00, 8'h00); hold(SYNC_LAT); step(8'h10, 8'h00); hold(SYNC_LAT); step(8'h10, 8'h00);
        step(8'h00, 8'h00); hold(SYNC_LAT); step(8'h10, 8'h00); hold(SYNC_LAT); settle();
        chk("t4 overrun set", overrun, 8'h10);
        step(8'h10, 8'h00, 1'b1, 3'd4); settle();
        chk("t4 overrun cleared", overrun, 8'h00);
        step(8'h10, 8'h00); step(8'h10, 8'h00); settle();
        chk("t4 pending empty", {7'd0, en_out}, 8'h00);

        // edge on the same cycle as its own ack: edge wins, no overrun
        step(8'h00, 8'h00); hold(SYNC_LAT); step(8'h10, 8'h00); hold(SYNC_LAT); step(8'h10, 8'h00);
        step(8'h00, 8'h00); hold(SYNC_LAT);
        if (SYNC_LAT > 0) begin
            step(8'h10, 8'h00); hold(SYNC_LAT - 1);
        end
        step(8'h10, 8'h00, 1'b1, 3'd4); settle();
        chk("t5 no overrun", overrun, 8'h00);
        step(8'h10, 8'h00); step(8'h10, 8'h00); settle();
        chk("t5 re-presented", d_out, 8'h10);
        step(8'h10, 8'h00, 1'b1, 3'd4); step(8'h10, 8'h00); step(8'h10, 8'h00);

        // asynchronous reset mid-service
        step(8'h00, 8'h00); hold(SYNC_LAT); step(8'h02, 8'h00); hold(SYNC_LAT); step(8'h02, 8'h00);
        step(8'h00, 8'h00); hold(SYNC_LAT); step(8'h02, 8'h00); hold(SYNC_LAT);
        step(8'h02, 8'h00, 1'b1, 3'd6); settle();
        #1;
        rst_n = 1'b0;
        irq_in = '0; ack = 1'b0; cur_irq = '0;
        #1;
        chk("areset en_out", {7'd0, en_out}, 8'h00);
        chk("areset d_out", d_out, 8'h00);
        chk("areset overrun", overrun, 8'h00);
        chk("areset ack_err", {7'd0, ack_err}, 8'h00);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        hold(4);

        // random traffic
        ri = '0; rm = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 7) == 0) ri[b] = ~ri[b];
            if ($urandom_range(0, 49) == 0) rm = 8'($urandom) & 8'($urandom);
            ra = 1'b0; rx = 3'($urandom);
            if (m_snap != 0 && $urandom_range(0, 2) == 0) begin
                ra = 1'b1;
                if ($urandom_range(0, 3) != 0)
                    for (int b = 0; b < 8; b++) if (m_snap[b]) rx = 3'(b);
            end else if ($urandom_range(0, 19) == 0) ra = 1'b1;
            step(ri, rm, ra, rx);
        end
        step(ri, rm);

        for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(posedge clk);
        #3;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
